// File: rtl/uart_cmd_sender.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_sender
// Description : Serialises a 2..4 byte register-file / ALU command onto a UART
//               line (start, LSB-first data, optional parity, stop).
// Revision    : 1.0
// ============================================================================
module uart_cmd_sender #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [1:0]            CMD_TYPE,
    input  logic [DATA_WIDTH-1:0] ARG0,
    input  logic [DATA_WIDTH-1:0] ARG1,
    input  logic [DATA_WIDTH-1:0] ARG2,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  CFG_ERR
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [IDX_W-1:0]      c_last_idx = IDX_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_W-1:0] c_ps_one   = PRESCALE_W'(1);

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [PRESCALE_W-1:0] r_bit_cnt;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [1:0]            r_byte_idx;
    logic [1:0]            r_type;
    logic [DATA_WIDTH-1:0] r_arg0;
    logic [DATA_WIDTH-1:0] r_arg1;
    logic [DATA_WIDTH-1:0] r_arg2;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_done;
    logic                  r_cfg_err;

    logic                  w_idle;
    logic                  w_accept;
    logic                  w_ps_ok;
    logic                  w_start;
    logic [PRESCALE_W-1:0] w_ps_m1;
    logic                  w_bit_last;
    logic                  w_data_last;
    logic                  w_byte_last;
    logic [1:0]            w_last_byte;
    logic [DATA_WIDTH-1:0] w_cur_byte;
    logic                  w_parity;

    assign w_idle      = (r_state == S_IDLE);
    assign w_accept    = CMD_VALID && w_idle;
    assign w_ps_ok     = (PRESCALE > c_ps_one);
    assign w_start     = w_accept && w_ps_ok;
    assign w_ps_m1     = r_prescale - c_ps_one;
    assign w_bit_last  = (r_bit_cnt == w_ps_m1);
    assign w_data_last = (r_bit_idx == c_last_idx);
    assign w_byte_last = (r_byte_idx == w_last_byte);
    assign w_parity    = (^w_cur_byte) ^ r_par_typ;

    // Byte 0 is the opcode implied by the type; later bytes are the arguments.
    always_comb begin
        w_last_byte = 2'd1;
        w_cur_byte  = '0;
        case (r_type)
            2'b00:   w_last_byte = 2'd2;
            2'b01:   w_last_byte = 2'd1;
            2'b10:   w_last_byte = 2'd3;
            default: w_last_byte = 2'd1;
        endcase
        case (r_byte_idx)
            2'd0: begin
                case (r_type)
                    2'b00:   w_cur_byte = DATA_WIDTH'(8'hAA);
                    2'b01:   w_cur_byte = DATA_WIDTH'(8'hBB);
                    2'b10:   w_cur_byte = DATA_WIDTH'(8'hCC);
                    default: w_cur_byte = DATA_WIDTH'(8'hDD);
                endcase
            end
            2'd1:    w_cur_byte = r_arg0;
            2'd2:    w_cur_byte = r_arg1;
            default: w_cur_byte = r_arg2;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_state_next = S_START;
            S_START:  if (w_bit_last) w_state_next = S_DATA;
            S_DATA:   if (w_bit_last && w_data_last) w_state_next = r_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (w_bit_last) w_state_next = S_STOP;
            S_STOP:   if (w_bit_last) w_state_next = w_byte_last ? S_IDLE : S_START;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_type     <= '0;
            r_arg0     <= '0;
            r_arg1     <= '0;
            r_arg2     <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_prescale <= '0;
            r_done     <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_done    <= (r_state == S_STOP) && w_bit_last && w_byte_last;
            r_cfg_err <= w_accept && !w_ps_ok;
            if (w_start) begin
                r_type     <= CMD_TYPE;
                r_arg0     <= ARG0;
                r_arg1     <= ARG1;
                r_arg2     <= ARG2;
                r_par_en   <= PAR_EN;
                r_par_typ  <= PAR_TYP;
                r_prescale <= PRESCALE;
                r_bit_cnt  <= '0;
                r_bit_idx  <= '0;
                r_byte_idx <= '0;
            end else if (!w_idle) begin
                if (w_bit_last) begin
                    r_bit_cnt <= '0;
                    if (r_state == S_DATA)
                        r_bit_idx <= w_data_last ? '0 : r_bit_idx + 1'b1;
                    if (r_state == S_STOP)
                        r_byte_idx <= w_byte_last ? 2'd0 : r_byte_idx + 2'd1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        TX_OUT = 1'b1;
        case (r_state)
            S_START:  TX_OUT = 1'b0;
            S_DATA:   TX_OUT = w_cur_byte[r_bit_idx];
            S_PARITY: TX_OUT = w_parity;
            default:  TX_OUT = 1'b1;
        endcase
    end

    assign CMD_READY = w_idle;
    assign BUSY      = !w_idle;
    assign DONE      = r_done;
    assign CFG_ERR   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_sender.sv
`default_nettype none
// Directed bench for uart_cmd_sender: every serial bit is checked cycle by
// cycle against hand-computed frames.
module tb_uart_cmd_sender;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       CMD_VALID = 1'b0;
    logic       CMD_READY;
    logic [1:0] CMD_TYPE = '0;
    logic [7:0] ARG0 = '0;
    logic [7:0] ARG1 = '0;
    logic [7:0] ARG2 = '0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] PRESCALE = '0;
    logic       TX_OUT;
    logic       BUSY;
    logic       DONE;
    logic       CFG_ERR;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    uart_cmd_sender #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_TYPE(CMD_TYPE), .ARG0(ARG0), .ARG1(ARG1), .ARG2(ARG2),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .PRESCALE(PRESCALE),
        .TX_OUT(TX_OUT), .BUSY(BUSY), .DONE(DONE), .CFG_ERR(CFG_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame: start, 8 data bits LSB first, optional parity, stop.
    task automatic check_frame(input logic [7:0] byt, input logic pe, input logic pbit,
                               input int ps, input logic noise);
        int   nbits;
        logic exp;
        nbits = pe ? 11 : 10;
        for (int b = 0; b < nbits; b++) begin
            if (b == 0)                exp = 1'b0;
            else if (b <= 8)           exp = byt[b-1];
            else if (pe && b == 9)     exp = pbit;
            else                       exp = 1'b1;
            for (int c = 0; c < ps; c++) begin
                chk("tx_bit", {31'd0, TX_OUT}, {31'd0, exp});
                chk("busy_ready", {30'd0, BUSY, CMD_READY}, 32'h2);
                chk("done_low", {31'd0, DONE}, 32'h0);
                cyc++;
                if (noise) begin
                    CMD_VALID = 1'b1;
                    CMD_TYPE  = 2'($urandom_range(0, 3));
                    ARG0      = 8'($urandom);
                    PRESCALE  = 6'($urandom);
                end
                tick();
            end
        end
    endtask

    task automatic check_stream(input logic [31:0] bytes, input int nb, input logic [3:0] pb,
                                input logic pe, input int ps, input int exp_cyc,
                                input logic noise);
        cyc = 0;
        for (int k = 0; k < nb; k++)
            check_frame(bytes[8*k +: 8], pe, pb[k], ps, noise);
        CMD_VALID = 1'b0;
        chk("active_cycles", cyc, exp_cyc);
        chk("done_pulse", {31'd0, DONE}, 32'h1);
        chk("ready_on_done", {30'd0, CMD_READY, BUSY}, 32'h2);
        chk("tx_idle_on_done", {31'd0, TX_OUT}, 32'h1);
    endtask

    task automatic issue(input logic [1:0] t, input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2, input logic pe, input logic pt,
                         input logic [5:0] ps);
        CMD_TYPE = t; ARG0 = a0; ARG1 = a1; ARG2 = a2;
        PAR_EN = pe; PAR_TYP = pt; PRESCALE = ps;
        CMD_VALID = 1'b1;
        chk("ready_at_accept", {31'd0, CMD_READY}, 32'h1);
        tick();
        CMD_VALID = 1'b0;
    endtask

    initial begin
        // Reset state
        RST = 1'b0;
        tick();
        tick();
        chk("rst_outputs", {27'd0, TX_OUT, CMD_READY, BUSY, DONE, CFG_ERR}, 32'h18);
        RST = 1'b1;
        tick();

        // RF read: BB, 03 at prescale 4, no parity -> 80 cycles
        issue(2'b01, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 6'd4);
        check_stream(32'h0000_03BB, 2, 4'b0000, 1'b0, 4, 80, 1'b0);
        tick();
        chk("done_one_cycle", {31'd0, DONE}, 32'h0);

        // RF write even parity: AA,05,AA all parity 0 -> 264 cycles
        issue(2'b00, 8'h05, 8'hAA, 8'h00, 1'b1, 1'b0, 6'd8);
        check_stream(32'h00AA_05AA, 3, 4'b0000, 1'b1, 8, 264, 1'b0);
        tick();

        // Same with odd parity: parity bits all 1
        issue(2'b00, 8'h05, 8'hAA, 8'h00, 1'b1, 1'b1, 6'd8);
        check_stream(32'h00AA_05AA, 3, 4'b0111, 1'b1, 8, 264, 1'b0);
        tick();

        // ALU op with CMD_VALID/inputs churning while busy -> CC,FF,FF,00, 640 cycles
        issue(2'b10, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 6'd16);
        check_stream(32'h00FF_FFCC, 4, 4'b0000, 1'b0, 16, 640, 1'b1);

        // Back-to-back accept on the DONE cycle: BB,5A odd parity -> 1,1; 44 cycles
        issue(2'b01, 8'h5A, 8'h00, 8'h00, 1'b1, 1'b1, 6'd2);
        chk("b2b_start_bit", {31'd0, TX_OUT}, 32'h0);
        check_stream(32'h0000_5ABB, 2, 4'b0011, 1'b1, 2, 44, 1'b0);
        tick();

        // PRESCALE=0 and 1 are rejected
        for (int p = 0; p < 2; p++) begin
            issue(2'b00, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 6'(p));
            chk("cfg_err_pulse", {27'd0, TX_OUT, CMD_READY, BUSY, DONE, CFG_ERR}, 32'h19);
            tick();
            chk("cfg_err_clear", {27'd0, TX_OUT, CMD_READY, BUSY, DONE, CFG_ERR}, 32'h18);
        end

        // Type 11: DD then 04, reset during second frame
        issue(2'b11, 8'h04, 8'h00, 8'h00, 1'b0, 1'b0, 6'd4);
        cyc = 0;
        check_frame(8'hDD, 1'b0, 1'b0, 4, 1'b0);
        for (int c = 0; c < 6; c++) tick();
        chk("mid_frame_busy", {31'd0, BUSY}, 32'h1);
        RST = 1'b0;
        tick();
        chk("abort_outputs", {27'd0, TX_OUT, CMD_READY, BUSY, DONE, CFG_ERR}, 32'h18);
        RST = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            chk("no_resume", {29'd0, TX_OUT, BUSY, DONE}, 32'h4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
